// File: rtl/vga_pkg.sv
// Shared VGA timing and colour constants, plus a small window helper.
// The display-side block_controller imports the same package, so both ends
// agree on the 640x480@60 timing without duplicating numbers.
package vga_pkg;

    // Default pixel divider: system clocks per pixel (power of two, >= 2).
    localparam int unsigned VGA_CLK_DIV     = 4;

    // Horizontal timing, in pixels.
    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_ACT_START = 144;
    localparam int unsigned VGA_H_ACT_END   = 783;

    // Vertical timing, in lines.
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_ACT_START = 35;
    localparam int unsigned VGA_V_ACT_END   = 514;

    // 12-bit RGB (4:4:4) colour constants.
    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] RED     = 12'hF00;
    localparam logic [11:0] GREEN   = 12'h0F0;
    localparam logic [11:0] BLUE    = 12'h00F;
    localparam logic [11:0] YELLOW  = 12'hFF0;
    localparam logic [11:0] MAGENTA = 12'hF0F;
    localparam logic [11:0] CYAN    = 12'h0FF;

    // Inclusive unsigned 10-bit range test used for the active window.
    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the sync generator and the renderer/DAC side.
// Strobe semantics: pix_en is a one-clk qualifier, high once per pixel
// period. hCount/vCount/bright change only in the clk after a pix_en and are
// stable in between; the renderer presents rgb_in combinationally from
// hCount/vCount and the generator captures it on pix_en (no back-pressure,
// the pixel stream never stalls). line_tick/frame_tick are single-clk pulses.
interface vga_sync_gen_if;
    logic [11:0] rgb_in;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        pix_en;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb_out;
    logic        frame_tick;
    logic        line_tick;

    // Generator side: drives timing and the registered pixel.
    modport master (
        input  rgb_in,
        output hCount, vCount, bright, pix_en,
        output hSync, vSync, rgb_out, frame_tick, line_tick
    );

    // Renderer/DAC side: supplies colour, consumes timing.
    modport slave (
        output rgb_in,
        input  hCount, vCount, bright, pix_en,
        input  hSync, vSync, rgb_out, frame_tick, line_tick
    );
endinterface

// File: rtl/vga_sync_gen_pix_divider.sv
// Pixel-rate divider: free-running 0..CLK_DIV-1 counter; pix_en marks the
// last clk of each pixel period so the first strobe after reset lands on the
// CLK_DIV-th clk.
module pix_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);
    localparam int unsigned   DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Next divider value: wrap explicitly at CLK_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // Divider register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Strobe decoded straight from the register; it is 0 while div_q is 0.
    assign pix_en_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, zero-latency active-window flag,
// and a one-pixel-latency output stage that keeps rgb_out, hSync and vSync
// aligned with each other for the DAC.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_ACT_START = VGA_H_ACT_START,
    parameter int unsigned H_ACT_END   = VGA_H_ACT_END,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_ACT_START = VGA_V_ACT_START,
    parameter int unsigned V_ACT_END   = VGA_V_ACT_END
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);
    // All counter comparisons are unsigned 10-bit.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_HI = 10'(H_ACT_END);
    localparam logic [9:0] V_ACT_LO = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_HI = 10'(V_ACT_END);

    logic        pix_en;
    logic        bright;

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_tick_q, line_tick_d;
    logic        frame_tick_q, frame_tick_d;

    pix_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_divider (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en)
    );

    // Counter next-state: advance one pixel per strobe, wrap at the totals.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Active window from the current counters, no register in between.
    assign bright = in_range(hcount_q, H_ACT_LO, H_ACT_HI) &&
                    in_range(vcount_q, V_ACT_LO, V_ACT_HI);

    // Output stage inputs and tick decode, evaluated on the current pixel.
    always_comb begin
        rgb_d        = bright ? vga.rgb_in : BLACK;
        hsync_d      = ~(hcount_q < H_SYNC_W);
        vsync_d      = ~(vcount_q < V_SYNC_W);
        line_tick_d  = pix_en && (hcount_q == H_LAST);
        frame_tick_d = line_tick_d && (vcount_q == V_ACT_HI);
    end

    // Counters, output stage and tick registers; reset aborts the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            rgb_q        <= BLACK;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
            if (pix_en) begin
                rgb_q   <= rgb_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign vga.hCount     = hcount_q;
    assign vga.vCount     = vcount_q;
    assign vga.bright     = bright;
    assign vga.pix_en     = pix_en;
    assign vga.hSync      = hsync_q;
    assign vga.vSync      = vsync_q;
    assign vga.rgb_out    = rgb_q;
    assign vga.line_tick  = line_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (power of two, at least 2).
REQ-002 Parameters H_TOTAL 800, H_SYNC 96, H_ACT_START 144, H_ACT_END 783: horizontal timing in pixels.
REQ-003 Parameters V_TOTAL 525, V_SYNC 2, V_ACT_START 35, V_ACT_END 514: vertical timing in lines.
REQ-004 clk  input  1  system clock. One clock domain only.
REQ-005 rst  input  1  reset. Synchronous, active-high.
REQ-006 rgb_in  input  12  pixel colour from the game/renderer logic, as a combinational function of hCount/vCount.
REQ-007 hCount  output  10  current pixel column, 0..H_TOTAL-1.
REQ-008 vCount  output  10  current line, 0..V_TOTAL-1.
REQ-009 bright  output  1  high when hCount/vCount are inside the active window.
REQ-010 pix_en  output  1  one-clk strobe, once every CLK_DIV clocks.
REQ-011 hSync  output  1  active-low horizontal sync, aligned with rgb_out.
REQ-012 vSync  output  1  active-low vertical sync, aligned with rgb_out.
REQ-013 rgb_out  output  12  registered pixel colour to the DAC.
REQ-014 frame_tick  output  1  one-clk pulse at the start of vertical blanking, used to step the game logic.
REQ-015 line_tick  output  1  one-clk pulse when hCount wraps to 0.

Function
REQ-016 The divider counter SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high only in the clk where the divider equals CLK_DIV-1.
REQ-017 On each pix_en, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 in the same update.
REQ-018 vCount SHALL increment only on pix_en with hCount = H_TOTAL-1; at V_TOTAL-1 it SHALL wrap to 0.
REQ-019 hCount and vCount SHALL be registers that change only on pix_en edges.
REQ-020 bright SHALL equal (H_ACT_START <= hCount <= H_ACT_END) AND (V_ACT_START <= vCount <= V_ACT_END).
REQ-021 bright SHALL be derived from the current counter values, with zero latency relative to hCount/vCount.
REQ-022 On each pix_en, the output stage SHALL register the following together, giving exactly one pixel of latency on all three:
  - rgb_out <= rgb_in if bright, else 0;
  - hSync <= ~(hCount < H_SYNC);
  - vSync <= ~(vCount < V_SYNC).
REQ-023 Between pix_en strobes, rgb_out, hSync and vSync SHALL hold their values.
REQ-024 line_tick SHALL pulse for one clk, in the clk after the pix_en that wraps hCount to 0.
REQ-025 frame_tick SHALL pulse for one clk, in the clk after the pix_en that moves vCount from V_ACT_END to V_ACT_END+1 (hCount = 0).
REQ-026 At the frame wrap (799,524 to 0,0), line_tick SHALL pulse and frame_tick SHALL NOT.
REQ-027 No counter SHALL ever hold a value at or above its TOTAL; all comparisons SHALL be unsigned 10-bit.

Reset
REQ-028 While rst is high at a clk edge, the block SHALL set:
  - divider = 0, hCount = 0, vCount = 0;
  - hSync = 1, vSync = 1;
  - rgb_out = 0;
  - pix_en = 0, frame_tick = 0, line_tick = 0.
REQ-029 After rst deasserts, the first pix_en SHALL occur on the CLK_DIV-th clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame; no partial tick SHALL be emitted after release.

Structure
REQ-031 Timing parameters and colour constants (BLACK, WHITE, etc.) SHALL live in a shared package, vga_pkg, also used by block_controller.
REQ-032 The block SHALL contain one sub-module, pix_divider, which generates pix_en.
REQ-033 Counters, sync and output registers SHALL stay in vga_sync_gen.

Verification
REQ-034 Reset release with CLK_DIV=4 -> pix_en first high at clk 4; hCount becomes 1 at clk 5; rgb_out = 0; hSync/vSync = 1 until the first pix_en.
REQ-035 Run one full frame -> exactly 420000 pix_en; exactly 525 line_tick; exactly 1 frame_tick, at hCount = 0, vCount = 515.
REQ-036 rgb_in = 12'hF0F constant -> rgb_out = F0F exactly for registered pixels (144..783, 35..514) and 0 elsewhere; 307200 non-zero pixels per frame.
REQ-037 Sync shape -> hSync low for 96 pixels per line, starting one pixel after hCount = 0; vSync low for 2 lines (1600 pixels).
REQ-038 Assert rst at hCount = 400, vCount = 200 for 3 clks -> all outputs at reset values; counting restarts from 0,0; first frame_tick occurs 515*800 pixels later.
REQ-039 Boundary wrap -> at hCount = 799, vCount = 524, the next pix_en gives 0,0 with line_tick = 1 and frame_tick = 0.
